// File: rtl/ps2_key_led_tracker.sv
// ps2_key_led_tracker
//
// Tracks PS/2 scan-code bytes from the receiver and turns them into key events.
// A make/break/extended-prefix FSM accepts only letters A-J and digits 0-9.
// Typematic repeats of the currently held key are dropped.
// Accepted codes go into a small circular history FIFO.
// The block also drives the red and green LED banks and exports decoded indices.
//
// Ports:
//   clock27     system clock, rising edge
//   reset       asynchronous active-high reset
//   key_strobe  one-cycle strobe qualifying key_data
//   key_data    scan-code byte
//   disp_mode   0: green shows last accepted code, 1: {letter_idx, number_idx}
//   hist_pop    pop oldest history entry
//   clear       synchronous flush of history, held key and outputs (not led_r)
//   led_r       raw last byte, zero-extended
//   led_g       registered green display value
//   letter_idx  last accepted letter (A=0..J=9, 15 = none)
//   number_idx  last accepted digit (1..9, 0 key = 10, 15 = none)
//   accept      one-cycle pulse per accepted key
//   hist_head   oldest history entry, 0 when empty
//   hist_count  number of valid history entries
//   hist_full   history holds HIST_DEPTH entries
//   overflow    sticky: a push was dropped because the history was full
module ps2_key_led_tracker #(
    parameter int HIST_DEPTH = 4,
    parameter int RED_W      = 10,
    parameter int GRN_W      = 8,
    parameter int CNT_W      = 5
) (
    input  logic             clock27,
    input  logic             reset,
    input  logic             key_strobe,
    input  logic [7:0]       key_data,
    input  logic             disp_mode,
    input  logic             hist_pop,
    input  logic             clear,
    output logic [RED_W-1:0] led_r,
    output logic [GRN_W-1:0] led_g,
    output logic [3:0]       letter_idx,
    output logic [3:0]       number_idx,
    output logic             accept,
    output logic [7:0]       hist_head,
    output logic [CNT_W-1:0] hist_count,
    output logic             hist_full,
    output logic             overflow
);

    localparam int PTR_W = $clog2(HIST_DEPTH);

    typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

    state_t           state_reg, state_next;
    logic             held_reg;
    logic [7:0]       held_code_reg;
    logic [7:0]       last_code_reg, last_code_next;
    logic [3:0]       letter_idx_reg, number_idx_reg;
    logic             accept_reg;
    logic [RED_W-1:0] led_r_reg;
    logic [GRN_W-1:0] led_g_reg, led_g_next;
    logic             overflow_reg;
    logic [7:0]       head_reg, head_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [7:0]       mem [HIST_DEPTH];

    logic             is_letter, is_digit;
    logic [3:0]       letter_val, digit_val;
    logic             make_eval, release_hit, accept_now;
    logic             fifo_empty, fifo_full, pop_do, push_do, push_drop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(HIST_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Scan-code decode of the accepted key set
    always_comb begin
        is_letter  = 1'b0;
        is_digit   = 1'b0;
        letter_val = 4'hF;
        digit_val  = 4'hF;
        case (key_data)
            8'h1C: begin is_letter = 1'b1; letter_val = 4'd0; end
            8'h32: begin is_letter = 1'b1; letter_val = 4'd1; end
            8'h21: begin is_letter = 1'b1; letter_val = 4'd2; end
            8'h23: begin is_letter = 1'b1; letter_val = 4'd3; end
            8'h24: begin is_letter = 1'b1; letter_val = 4'd4; end
            8'h2B: begin is_letter = 1'b1; letter_val = 4'd5; end
            8'h34: begin is_letter = 1'b1; letter_val = 4'd6; end
            8'h33: begin is_letter = 1'b1; letter_val = 4'd7; end
            8'h43: begin is_letter = 1'b1; letter_val = 4'd8; end
            8'h3B: begin is_letter = 1'b1; letter_val = 4'd9; end
            8'h16: begin is_digit = 1'b1; digit_val = 4'd1; end
            8'h1E: begin is_digit = 1'b1; digit_val = 4'd2; end
            8'h26: begin is_digit = 1'b1; digit_val = 4'd3; end
            8'h25: begin is_digit = 1'b1; digit_val = 4'd4; end
            8'h2E: begin is_digit = 1'b1; digit_val = 4'd5; end
            8'h36: begin is_digit = 1'b1; digit_val = 4'd6; end
            8'h3D: begin is_digit = 1'b1; digit_val = 4'd7; end
            8'h3E: begin is_digit = 1'b1; digit_val = 4'd8; end
            8'h46: begin is_digit = 1'b1; digit_val = 4'd9; end
            8'h45: begin is_digit = 1'b1; digit_val = 4'd10; end
            default: ;
        endcase
    end

    // Prefix FSM. A strobe coinciding with clear is discarded entirely.
    always_comb begin
        state_next  = state_reg;
        make_eval   = 1'b0;
        release_hit = 1'b0;
        if (key_strobe && !clear) begin
            case (state_reg)
                IDLE: begin
                    if (key_data == 8'hF0)      state_next = BRK;
                    else if (key_data == 8'hE0) state_next = EXT;
                    else                        make_eval  = 1'b1;
                end
                BRK: begin
                    release_hit = (key_data == held_code_reg);
                    state_next  = IDLE;
                end
                EXT:     state_next = (key_data == 8'hF0) ? EXT_BRK : IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    assign accept_now = make_eval && (is_letter || is_digit) &&
                        !(held_reg && key_data == held_code_reg);

    // History FIFO control; a pop in the same cycle makes room for a push
    always_comb begin
        fifo_empty  = (count_reg == '0);
        fifo_full   = (count_reg == CNT_W'(HIST_DEPTH));
        pop_do      = hist_pop && !clear && !fifo_empty;
        push_do     = accept_now && (!fifo_full || pop_do);
        push_drop   = accept_now && fifo_full && !pop_do;
        rd_ptr_next = pop_do  ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;
        wr_ptr_next = push_do ? ptr_inc(wr_ptr_reg) : wr_ptr_reg;
        count_next  = count_reg;
        if (push_do && !pop_do)      count_next = count_reg + CNT_W'(1);
        else if (pop_do && !push_do) count_next = count_reg - CNT_W'(1);
        // The new head can be the entry being written this very cycle
        if (count_next == '0)                      head_next = 8'h00;
        else if (push_do && wr_ptr_reg == rd_ptr_next) head_next = key_data;
        else                                       head_next = mem[rd_ptr_next];
    end

    // Mode 0 tracks the new code with one cycle of latency; mode 1 uses the
    // registered indices and therefore lags one more cycle
    always_comb begin
        last_code_next = accept_now ? key_data : last_code_reg;
        if (disp_mode) led_g_next = GRN_W'({letter_idx_reg, number_idx_reg});
        else           led_g_next = GRN_W'(last_code_next);
    end

    always_ff @(posedge clock27) begin
        if (push_do) mem[wr_ptr_reg] <= key_data;
    end

    always_ff @(posedge clock27 or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            held_reg       <= 1'b0;
            held_code_reg  <= 8'h00;
            last_code_reg  <= 8'h00;
            letter_idx_reg <= 4'hF;
            number_idx_reg <= 4'hF;
            accept_reg     <= 1'b0;
            led_r_reg      <= '0;
            led_g_reg      <= '0;
            overflow_reg   <= 1'b0;
            head_reg       <= 8'h00;
            count_reg      <= '0;
            rd_ptr_reg     <= '0;
            wr_ptr_reg     <= '0;
        end else begin
            if (key_strobe) led_r_reg <= RED_W'(key_data);
            if (clear) begin
                state_reg      <= IDLE;
                held_reg       <= 1'b0;
                held_code_reg  <= 8'h00;
                last_code_reg  <= 8'h00;
                letter_idx_reg <= 4'hF;
                number_idx_reg <= 4'hF;
                accept_reg     <= 1'b0;
                led_g_reg      <= '0;
                overflow_reg   <= 1'b0;
                head_reg       <= 8'h00;
                count_reg      <= '0;
                rd_ptr_reg     <= '0;
                wr_ptr_reg     <= '0;
            end else begin
                state_reg     <= state_next;
                accept_reg    <= accept_now;
                last_code_reg <= last_code_next;
                led_g_reg     <= led_g_next;
                head_reg      <= head_next;
                count_reg     <= count_next;
                rd_ptr_reg    <= rd_ptr_next;
                wr_ptr_reg    <= wr_ptr_next;
                if (push_drop) overflow_reg <= 1'b1;
                if (accept_now) begin
                    held_reg      <= 1'b1;
                    held_code_reg <= key_data;
                    if (is_letter) letter_idx_reg <= letter_val;
                    if (is_digit)  number_idx_reg <= digit_val;
                end else if (release_hit) begin
                    held_reg <= 1'b0;
                end
            end
        end
    end

    assign led_r      = led_r_reg;
    assign led_g      = led_g_reg;
    assign letter_idx = letter_idx_reg;
    assign number_idx = number_idx_reg;
    assign accept     = accept_reg;
    assign hist_head  = head_reg;
    assign hist_count = count_reg;
    assign hist_full  = (count_reg == CNT_W'(HIST_DEPTH));
    assign overflow   = overflow_reg;

endmodule

// File: tb/tb_ps2_key_led_tracker.sv
// Testbench for ps2_key_led_tracker: scoreboard of expected accepted codes,
// popped whenever the DUT pulses accept, plus direct output checks.
module tb_ps2_key_led_tracker;

    localparam int HIST_DEPTH = 4;
    localparam int RED_W      = 10;
    localparam int GRN_W      = 8;
    localparam int CNT_W      = 5;

    logic             clock27 = 1'b0;
    logic             reset = 1'b1;
    logic             key_strobe = 1'b0;
    logic [7:0]       key_data = 8'h00;
    logic             disp_mode = 1'b0;
    logic             hist_pop = 1'b0;
    logic             clear = 1'b0;
    logic [RED_W-1:0] led_r;
    logic [GRN_W-1:0] led_g;
    logic [3:0]       letter_idx, number_idx;
    logic             accept;
    logic [7:0]       hist_head;
    logic [CNT_W-1:0] hist_count;
    logic             hist_full, overflow;

    ps2_key_led_tracker #(
        .HIST_DEPTH(HIST_DEPTH), .RED_W(RED_W), .GRN_W(GRN_W), .CNT_W(CNT_W)
    ) dut (
        .clock27(clock27), .reset(reset), .key_strobe(key_strobe),
        .key_data(key_data), .disp_mode(disp_mode), .hist_pop(hist_pop),
        .clear(clear), .led_r(led_r), .led_g(led_g), .letter_idx(letter_idx),
        .number_idx(number_idx), .accept(accept), .hist_head(hist_head),
        .hist_count(hist_count), .hist_full(hist_full), .overflow(overflow)
    );

    always #5 clock27 = ~clock27;

    int         checks = 0;
    int         errors = 0;
    int         accepts = 0;
    logic [7:0] exp_q[$];
    logic [7:0] sb_code;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every accept pulse must match the next expected code
    always @(negedge clock27) begin
        if (accept === 1'b1) begin
            accepts++;
            if (exp_q.size() == 0) begin
                check("spurious_accept", 32'(accept), 32'd0);
            end else begin
                sb_code = exp_q.pop_front();
                if (!disp_mode) check("accept_led_g", 32'(led_g), 32'(sb_code));
                $display("accept: code 0x%02h led_g 0x%02h count %0d", sb_code, led_g, hist_count);
            end
        end
    end

    task automatic send(input logic [7:0] b, input bit acc, input bit pop);
        if (acc) exp_q.push_back(b);
        @(negedge clock27);
        key_strobe = 1'b1;
        key_data   = b;
        hist_pop   = pop;
        @(negedge clock27);
        #1;
        key_strobe = 1'b0;
        hist_pop   = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] head);
        @(negedge clock27);
        hist_pop = 1'b1;
        @(negedge clock27);
        #1;
        hist_pop = 1'b0;
        check(tag, 32'(hist_head), 32'(head));
    endtask

    task automatic do_clear();
        @(negedge clock27);
        clear = 1'b1;
        @(negedge clock27);
        #1;
        clear = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        repeat (3) @(negedge clock27);
        reset = 1'b0;
        #1;
        // Reset state
        check("rst_led_r", 32'(led_r), 0);
        check("rst_led_g", 32'(led_g), 0);
        check("rst_letter", 32'(letter_idx), 15);
        check("rst_number", 32'(number_idx), 15);
        check("rst_accept", 32'(accept), 0);
        check("rst_count", 32'(hist_count), 0);
        check("rst_head", 32'(hist_head), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_full", 32'(hist_full), 0);

        // Single letter make code
        send(8'h1C, 1, 0);
        check("t1_accept", 32'(accept), 1);
        check("t1_led_g", 32'(led_g), 32'h1C);
        check("t1_letter", 32'(letter_idx), 0);
        check("t1_number", 32'(number_idx), 15);
        check("t1_count", 32'(hist_count), 1);
        check("t1_head", 32'(hist_head), 32'h1C);
        check("t1_led_r", 32'(led_r), 32'h01C);
        @(negedge clock27);
        #1;
        check("t1_accept_pulse", 32'(accept), 0);

        // Typematic repeat then release and re-press
        do_clear();
        a0 = accepts;
        send(8'h45, 1, 0);
        send(8'h45, 0, 0);
        send(8'h45, 0, 0);
        send(8'hF0, 0, 0);
        send(8'h45, 0, 0);
        send(8'h45, 1, 0);
        check("t2_accepts", 32'(accepts - a0), 2);
        check("t2_number", 32'(number_idx), 10);
        check("t2_count", 32'(hist_count), 2);

        // Extended keys are never accepted
        a0 = accepts;
        send(8'hE0, 0, 0);
        send(8'h1C, 0, 0);
        send(8'hE0, 0, 0);
        send(8'hF0, 0, 0);
        send(8'h1C, 0, 0);
        check("t3_accepts", 32'(accepts - a0), 0);
        check("t3_count", 32'(hist_count), 2);
        check("t3_led_r", 32'(led_r), 32'h01C);
        send(8'h32, 1, 0);
        check("t3_idle_accept", 32'(hist_count), 3);
        check("t3_letter", 32'(letter_idx), 1);

        // Strobe coinciding with clear only reaches led_r
        @(negedge clock27);
        key_strobe = 1'b1;
        key_data   = 8'h2B;
        clear      = 1'b1;
        @(negedge clock27);
        #1;
        key_strobe = 1'b0;
        clear      = 1'b0;
        check("clr_led_r", 32'(led_r), 32'h02B);
        check("clr_count", 32'(hist_count), 0);
        check("clr_letter", 32'(letter_idx), 15);
        check("clr_number", 32'(number_idx), 15);
        check("clr_led_g", 32'(led_g), 0);
        check("clr_accept", 32'(accept), 0);

        // Overflow and drain
        send(8'h1C, 1, 0);
        send(8'h32, 1, 0);
        send(8'h21, 1, 0);
        send(8'h23, 1, 0);
        check("t4_overflow_pre", 32'(overflow), 0);
        send(8'h24, 1, 0);
        check("t4_full", 32'(hist_full), 1);
        check("t4_overflow", 32'(overflow), 1);
        check("t4_count", 32'(hist_count), 4);
        check("t4_head", 32'(hist_head), 32'h1C);
        check("t4_letter", 32'(letter_idx), 4);
        pop_expect("t4_pop1", 8'h32);
        pop_expect("t4_pop2", 8'h21);
        pop_expect("t4_pop3", 8'h23);
        pop_expect("t4_pop4", 8'h00);
        check("t4_empty", 32'(hist_count), 0);
        pop_expect("t4_pop_empty", 8'h00);
        check("t4_empty_count", 32'(hist_count), 0);
        check("t4_overflow_sticky", 32'(overflow), 1);

        // Push and pop in the same cycle while full
        do_clear();
        send(8'h1C, 1, 0);
        send(8'h32, 1, 0);
        send(8'h21, 1, 0);
        send(8'h24, 1, 0);
        send(8'h16, 1, 1);
        check("t5_count", 32'(hist_count), 4);
        check("t5_full", 32'(hist_full), 1);
        check("t5_overflow", 32'(overflow), 0);
        check("t5_head", 32'(hist_head), 32'h32);
        check("t5_led_g_mode0", 32'(led_g), 32'h16);
        check("t5_number", 32'(number_idx), 1);
        @(negedge clock27);
        disp_mode = 1'b1;
        @(negedge clock27);
        #1;
        check("t5_led_g_mode1", 32'(led_g), 32'h41);
        disp_mode = 1'b0;
        pop_expect("t5_pop1", 8'h21);
        pop_expect("t5_pop2", 8'h24);
        pop_expect("t5_pop3", 8'h16);

        // Reset in the middle of a break sequence
        send(8'hF0, 0, 0);
        @(negedge clock27);
        reset = 1'b1;
        @(negedge clock27);
        #1;
        reset = 1'b0;
        check("t6_led_r", 32'(led_r), 0);
        check("t6_count", 32'(hist_count), 0);
        send(8'h32, 1, 0);
        check("t6_accept", 32'(accept), 1);
        check("t6_letter", 32'(letter_idx), 1);
        check("t6_count_after", 32'(hist_count), 1);

        repeat (2) @(negedge clock27);
        #1;
        check("queue_drained", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_key_led_tracker.md
Name: ps2_key_led_tracker

Overview:
- Successor to the single-register key-to-LED controller.
- Consumes byte strobes from the PS/2 receiver and runs a make/break/extended-prefix state machine.
- Filters the accepted key set (letters A–J, digits 0–9), suppresses typematic auto-repeat, and keeps a parametrised-depth history of accepted keys.
- Drives the red/green LED banks and also exports decoded letter/number indices to the game logic.

Parameters:
- HIST_DEPTH, 4: entries in the accepted-key history FIFO; legal range 2..16.
- RED_W, 10: red LED bank width; shows the raw last byte, zero-extended (RED_W >= 8).
- GRN_W, 8: green LED bank width (GRN_W >= 8).
- CNT_W, 5: width of the history count output; must satisfy 2^CNT_W > HIST_DEPTH.

Ports:
- clock27, input, 1: system clock; all state changes on its rising edge.
- reset, input, 1: asynchronous, active-high reset.
- key_strobe, input, 1: one-cycle pulse; key_data is valid this cycle.
- key_data, input, 8: scan-code byte from the PS/2 receiver.
- disp_mode, input, 1: 0 = green shows the last accepted code; 1 = green shows {letter_idx, number_idx}.
- hist_pop, input, 1: pops the oldest history entry.
- clear, input, 1: synchronous flush of history, held key and outputs.
- led_r, output, RED_W: raw last byte received.
- led_g, output, GRN_W: display value selected by disp_mode.
- letter_idx, output, 4: last accepted letter; A=0 .. J=9; 15 = none.
- number_idx, output, 4: last accepted digit; 1..9, 0 key = 10; 15 = none.
- accept, output, 1: one-cycle pulse when a key is accepted into history.
- hist_head, output, 8: oldest history code; 0 when empty.
- hist_count, output, CNT_W: number of valid history entries.
- hist_full, output, 1: hist_count == HIST_DEPTH.
- overflow, output, 1: sticky; set when a push is dropped because the FIFO is full.

Behaviour:
- Reset values (also restored by clear, except led_r):
  - led_r = 0, led_g = 0, letter_idx = 15, number_idx = 15, accept = 0.
  - hist_count = 0, hist_head = 0, overflow = 0, held = 0, state = IDLE.
  - clear leaves led_r unchanged.
- led_r <= {0, key_data} on every key_strobe, regardless of FSM state.
- FSM states: IDLE, BRK, EXT, EXT_BRK. Transitions happen only on key_strobe:
  - IDLE: 0xF0 -> BRK; 0xE0 -> EXT; any other byte is a make code, evaluated, and the FSM stays in IDLE.
  - BRK: any byte is a release code. If it equals held_code, held clears. -> IDLE.
  - EXT: 0xF0 -> EXT_BRK; any other byte is ignored (extended keys are never accepted). -> IDLE.
  - EXT_BRK: any byte is ignored. -> IDLE.
- Accepted set:
  - Letters: 1C A, 32 B, 21 C, 23 D, 24 E, 2B F, 34 G, 33 H, 43 I, 3B J.
  - Digits: 16 1, 1E 2, 26 3, 25 4, 2E 5, 36 6, 3D 7, 3E 8, 46 9, 45 0.
  - Decode is combinational from key_data.
- Make-code evaluation in IDLE:
  - Byte not in the accepted set: no effect beyond led_r.
  - Byte in the set and held && code == held_code: typematic repeat; ignored.
  - Otherwise the key is accepted. On the next edge:
    - accept pulses high for one cycle.
    - held_code <= code, held <= 1.
    - last_code <= code.
    - letter_idx or number_idx updates (only the matching one changes).
    - The code is pushed to the FIFO.
- Green display:
  - disp_mode = 0: led_g = last_code, zero-extended.
  - disp_mode = 1: led_g = {letter_idx, number_idx}, zero-extended.
  - led_g is registered and updates the cycle after a change to disp_mode or to its source.
- FIFO, circular with read and write pointers mod HIST_DEPTH:
  - Push when full: the push is dropped and overflow is set. accept still pulses and the indices still update.
  - hist_pop when empty: no effect.
  - Push and pop in the same cycle: both happen; count is unchanged. When full, the pop frees space, so the push succeeds.
  - hist_head is registered, equals the oldest entry, and reads 0 when empty.
- Priority: reset > clear > strobe/pop. A key_strobe in the same cycle as clear is discarded, except for its effect on led_r.
- Latency: key_strobe to accept/led_g(mode 0)/indices = 1 cycle. led_g in mode 1 = 2 cycles.
- Reset asserted mid-sequence (e.g. in BRK) returns the FSM to IDLE. The next byte is treated as a make code.

Test Plan:
- Reset, then strobe 0x1C -> accept pulses 1 cycle later; led_g = 0x1C; letter_idx = 0; number_idx = 15; hist_count = 1; hist_head = 0x1C; led_r = 0x01C.
- Strobe 0x45, 0x45, 0x45 (typematic), then 0xF0, 0x45, then 0x45 -> exactly 2 accepts; number_idx = 10; hist_count = 2.
- Strobe 0xE0, 0x1C, then 0xE0, 0xF0, 0x1C -> no accept; hist_count unchanged; led_r = 0x01C; FSM back in IDLE.
- Push 5 distinct keys (1C, 32, 21, 23, 24) with HIST_DEPTH = 4 -> hist_full = 1; overflow = 1; hist_head = 0x1C. Then pop 4 times -> heads 32, 21, 23 in sequence, then empty with hist_head = 0.
- When full, strobe 0x16 with hist_pop in the same cycle -> count stays 4; 0x16 is stored at the tail; overflow stays unchanged. Then set disp_mode = 1 with letter_idx = 4, number_idx = 1 -> led_g = 0x41.
- Assert reset in BRK after 0xF0, release it, then strobe 0x32 -> accepted; letter_idx = 1.
